// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole game scheduler: spawns targets, times dwell/gap, scores hits and misses
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse: start or restart a game (highest priority)
//   rand_seg   in   random segment source, sampled in SPAWN (7 maps to 0)
//   hit        in   pulse: correct segment struck
//   wrong      in   pulse: wrong segment struck
//   mole_seg   out  current target segment, 0..6
//   mole_valid out  high while a mole is displayed (SHOW)
//   spawn      out  one-cycle pulse when a new mole_seg is loaded
//   level      out  current level, 0..15
//   misses     out  misses this game
//   game_over  out  high in OVER
module mole_scheduler #(
  parameter logic [15:0] DWELL_INIT     = 16'd40000,
  parameter logic [15:0] DWELL_STEP     = 16'd4000,
  parameter logic [15:0] DWELL_MIN      = 16'd8000,
  parameter logic [15:0] GAP_CYCLES     = 16'd2000,
  parameter logic [3:0]  HITS_PER_LEVEL = 4'd5,
  parameter logic [1:0]  MAX_MISSES     = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] rand_seg,
  input  logic       hit,
  input  logic       wrong,
  output logic [2:0] mole_seg,
  output logic       mole_valid,
  output logic       spawn,
  output logic [3:0] level,
  output logic [1:0] misses,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_SHOW,
    S_GAP,
    S_OVER
  } state_t;

  state_t      state;
  logic [3:0]  hit_cnt;
  logic [15:0] dwell;
  logic [15:0] timer;

  logic [2:0]  cand;
  logic [2:0]  seg_pick;
  logic [3:0]  hit_cnt_inc;
  logic [1:0]  misses_inc;
  logic [15:0] dwell_next;

  always_comb begin
    cand = (rand_seg == 3'd7) ? 3'd0 : rand_seg;
    seg_pick = cand;
    // Never show the same segment twice in a row: step to the next one, wrapping 6 -> 0.
    if (cand == mole_seg) begin
      seg_pick = (cand == 3'd6) ? 3'd0 : cand + 3'd1;
    end
    hit_cnt_inc = hit_cnt + 4'd1;
    misses_inc  = misses + 2'd1;
    // Shorten dwell by one step but never below the floor; the first term guards the subtraction.
    if ((dwell > DWELL_STEP) && ((dwell - DWELL_STEP) > DWELL_MIN)) begin
      dwell_next = dwell - DWELL_STEP;
    end else begin
      dwell_next = DWELL_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mole_seg   <= 3'd0;
      mole_valid <= 1'b0;
      spawn      <= 1'b0;
      level      <= 4'd0;
      misses     <= 2'd0;
      game_over  <= 1'b0;
      hit_cnt    <= 4'd0;
      dwell      <= DWELL_INIT;
      timer      <= 16'd0;
    end else begin
      spawn <= 1'b0;
      if (start) begin
        // Restart from any state; an in-flight mole is dropped without a miss.
        state      <= S_SPAWN;
        level      <= 4'd0;
        misses     <= 2'd0;
        hit_cnt    <= 4'd0;
        dwell      <= DWELL_INIT;
        mole_valid <= 1'b0;
        game_over  <= 1'b0;
        timer      <= 16'd0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_SPAWN: begin
            mole_seg   <= seg_pick;
            spawn      <= 1'b1;
            mole_valid <= 1'b1;
            timer      <= dwell;
            state      <= S_SHOW;
          end
          S_SHOW: begin
            // A hit outranks a simultaneous wrong strike or timeout.
            if (hit) begin
              mole_valid <= 1'b0;
              timer      <= GAP_CYCLES;
              state      <= S_GAP;
              if (hit_cnt_inc == HITS_PER_LEVEL) begin
                hit_cnt <= 4'd0;
                if (level != 4'd15) begin
                  level <= level + 4'd1;
                end
                dwell <= dwell_next;
              end else begin
                hit_cnt <= hit_cnt_inc;
              end
            end else if (wrong || (timer <= 16'd1)) begin
              misses     <= misses_inc;
              mole_valid <= 1'b0;
              if (misses_inc == MAX_MISSES) begin
                game_over <= 1'b1;
                state     <= S_OVER;
              end else begin
                timer <= GAP_CYCLES;
                state <= S_GAP;
              end
            end else begin
              timer <= timer - 16'd1;
            end
          end
          S_GAP: begin
            if (timer <= 16'd1) begin
              state <= S_SPAWN;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          S_OVER: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - directed self-checking bench for mole_scheduler
module tb_mole_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] rand_seg;
  logic       hit;
  logic       wrong;
  logic [2:0] mole_seg;
  logic       mole_valid;
  logic       spawn;
  logic [3:0] level;
  logic [1:0] misses;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  mole_scheduler #(
    .DWELL_INIT    (16'd8),
    .DWELL_STEP    (16'd2),
    .DWELL_MIN     (16'd4),
    .GAP_CYCLES    (16'd2),
    .HITS_PER_LEVEL(4'd2),
    .MAX_MISSES    (2'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rand_seg  (rand_seg),
    .hit       (hit),
    .wrong     (wrong),
    .mole_seg  (mole_seg),
    .mole_valid(mole_valid),
    .spawn     (spawn),
    .level     (level),
    .misses    (misses),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic hit_now();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask

  task automatic wait_spawn(input logic [2:0] rs, output int k);
    rand_seg = rs;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!spawn && k < 50);
    if (!spawn) check("spawn_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_show(output int len);
    len = 0;
    while (mole_valid && len < 100) begin
      len++;
      cyc();
    end
  endtask

  initial begin
    int k;
    int len;
    rst_n = 1'b0; start = 1'b0; rand_seg = 3'd0; hit = 1'b0; wrong = 1'b0;
    #2;
    check("rst_mole_seg", mole_seg, 0);
    check("rst_valid", mole_valid, 0);
    check("rst_spawn", spawn, 0);
    check("rst_level", level, 0);
    check("rst_misses", misses, 0);
    check("rst_over", game_over, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Game A: timing of first mole, timeout miss, gap, and segment selection rules.
    pulse_start();
    wait_spawn(3'd3, k);
    check("first_spawn_lat", k, 1);
    check("first_seg", mole_seg, 3);
    measure_show(len);
    check("show_len_init", len, 8);
    check("miss_after_timeout", misses, 1);
    wait_spawn(3'd7, k);
    check("gap_plus_spawn", k, 3);
    check("seg_rand7", mole_seg, 0);
    hit_now();
    wait_spawn(3'd4, k);
    check("seg_4", mole_seg, 4);
    hit_now();
    check("level_after_2", level, 1);
    wait_spawn(3'd4, k);
    check("seg_repeat4", mole_seg, 5);
    hit_now();
    wait_spawn(3'd6, k);
    check("seg_6", mole_seg, 6);
    hit_now();
    wait_spawn(3'd6, k);
    check("seg_repeat6", mole_seg, 0);

    // Game B: restart mid-SHOW, dwell shrinking to the floor, game over.
    pulse_start();
    check("restart_valid", mole_valid, 0);
    check("restart_level", level, 0);
    check("restart_misses", misses, 0);
    wait_spawn(3'd2, k);
    measure_show(len);
    check("show_len_l0", len, 8);
    for (int i = 0; i < 2; i++) begin
      wait_spawn(3'd3, k); cyc(); hit_now();
    end
    check("level_b1", level, 1);
    wait_spawn(3'd1, k);
    measure_show(len);
    check("show_len_l1", len, 6);
    for (int i = 0; i < 2; i++) begin
      wait_spawn(3'd5, k); cyc(); hit_now();
    end
    check("level_b2", level, 2);
    for (int i = 0; i < 2; i++) begin
      wait_spawn(3'd2, k); cyc(); hit_now();
    end
    check("level_b3", level, 3);
    wait_spawn(3'd0, k);
    measure_show(len);
    check("show_len_floor", len, 4);
    check("over_flag", game_over, 1);
    check("over_misses", misses, 3);
    check("over_valid", mole_valid, 0);
    cyc(); cyc(); cyc();
    check("over_hold", game_over, 1);
    check("over_level_frozen", level, 3);

    // Game C: start from OVER, hit+wrong, hits outside SHOW, hit on the last SHOW cycle.
    pulse_start();
    check("c_over_clr", game_over, 0);
    check("c_level", level, 0);
    check("c_misses", misses, 0);
    wait_spawn(3'd2, k);
    check("c_spawn_lat", k, 1);
    hit = 1'b1; wrong = 1'b1;
    cyc();
    hit = 1'b0; wrong = 1'b0;
    check("hitwrong_misses", misses, 0);
    check("hitwrong_gap", mole_valid, 0);
    hit_now();
    check("gap_hit_ignored", level, 0);
    wait_spawn(3'd4, k);
    for (int i = 0; i < 7; i++) cyc();
    check("last_show_cycle", mole_valid, 1);
    hit_now();
    check("last_cycle_hit_misses", misses, 0);
    check("last_cycle_hit_level", level, 1);
    wait_spawn(3'd5, k);
    wrong = 1'b1;
    cyc();
    wrong = 1'b0;
    check("wrong_miss", misses, 1);

    // Game D: level saturation, then three consecutive timeouts.
    pulse_start();
    for (int i = 0; i < 36; i++) begin
      wait_spawn(3'(i % 8), k);
      hit_now();
    end
    check("level_sat", level, 15);
    check("sat_misses", misses, 0);
    for (int i = 0; i < 3; i++) begin
      wait_spawn(3'd1, k);
      measure_show(len);
    end
    check("d_show_len", len, 4);
    check("d_over", game_over, 1);
    check("d_misses", misses, 3);
    check("d_level_frozen", level, 15);

    // Asynchronous reset while a mole is showing.
    pulse_start();
    wait_spawn(3'd3, k);
    cyc();
    rst_n = 1'b0;
    #1;
    check("arst_mole_seg", mole_seg, 0);
    check("arst_valid", mole_valid, 0);
    check("arst_spawn", spawn, 0);
    check("arst_level", level, 0);
    check("arst_misses", misses, 0);
    check("arst_over", game_over, 0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    check("post_rst_idle", mole_valid, 0);
    check("post_rst_nospawn", spawn, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
